// File: rtl/qbus_mem_slave_ctl.sv
// qbus_mem_slave_ctl: Q-bus slave sequencer bridging f11 bus strobes to a synchronous RAM,
// with DATI/DATO(B)/DATIO data phases, RPLY generation and a fixed-vector interrupt acknowledge.
module qbus_mem_slave_ctl #(
  parameter logic [15:0] BASE    = 16'h0000,
  parameter logic [15:0] MASK    = 16'hE000,
  parameter int          AW      = 12,
  parameter int          MEM_LAT = 1,
  parameter logic [15:0] VEC     = 16'h0030
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   bus_ad_n,
  input  logic          bus_sync_n,
  input  logic          bus_din_n,
  input  logic          bus_dout_n,
  input  logic          bus_wtbt_n,
  input  logic          bus_iako_n,
  output logic [15:0]   bus_ad_n_o,
  output logic          bus_ad_oe,
  output logic          bus_rply_n,
  output logic          bus_virq_n,
  input  logic          irq_set,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [1:0]    mem_be,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [15:0]   mem_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_SKIP, S_ADDR, S_RDW, S_RPLY, S_IAK} state_t;
  state_t      r_state;
  logic        r_sync_d;
  logic        r_pend;
  logic        r_a0;
  logic [2:0]  r_cnt;
  logic [15:0] w_a;
  logic        w_sync_fall;
  logic        w_sel;
  logic        w_iak;
  assign w_a         = ~bus_ad_n;
  assign w_sync_fall = ~bus_sync_n & r_sync_d;
  assign w_sel       = (w_a & MASK) == BASE;
  assign w_iak       = (r_state == S_IDLE) & bus_sync_n & ~bus_din_n & ~bus_iako_n & r_pend;
  assign bus_virq_n  = ~r_pend;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync_d   <= 1'b1;
      r_pend     <= 1'b0;
      r_a0       <= 1'b0;
      r_cnt      <= 3'd0;
      bus_ad_n_o <= 16'hFFFF;
      bus_ad_oe  <= 1'b0;
      bus_rply_n <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= 16'h0000;
      mem_be     <= 2'b00;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      r_sync_d <= bus_sync_n;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      // a new request arriving with the acknowledge wins, so it is not lost
      if (irq_set) r_pend <= 1'b1;
      else if (w_iak) r_pend <= 1'b0;
      case (r_state)
        S_IDLE:
          if (w_sync_fall) begin
            r_a0 <= w_a[0];
            if (w_sel) begin
              mem_addr <= w_a[AW:1];
              r_state  <= S_ADDR;
            end else r_state <= S_SKIP;
          end else if (w_iak) begin
            bus_ad_n_o <= ~VEC;
            bus_ad_oe  <= 1'b1;
            bus_rply_n <= 1'b0;
            r_state    <= S_IAK;
          end
        S_SKIP: if (bus_sync_n) r_state <= S_IDLE;
        S_ADDR:
          if (!bus_din_n && bus_dout_n) begin
            mem_re  <= 1'b1;
            r_cnt   <= 3'(MEM_LAT);
            r_state <= S_RDW;
          end else if (bus_din_n && !bus_dout_n) begin
            mem_wdata <= w_a;
            mem_be    <= !bus_wtbt_n ? (r_a0 ? 2'b10 : 2'b01) : 2'b11;
            mem_we    <= 1'b1;
            r_state   <= S_RPLY;
          end else if (bus_din_n && bus_sync_n) r_state <= S_IDLE;
        S_RDW:
          if (r_cnt == 3'd0) begin
            bus_ad_n_o <= ~mem_rdata;
            bus_ad_oe  <= 1'b1;
            bus_rply_n <= 1'b0;
            r_state    <= S_RPLY;
          end else r_cnt <= r_cnt - 3'd1;
        S_RPLY:
          if (bus_din_n && bus_dout_n) begin
            bus_rply_n <= 1'b1;
            bus_ad_oe  <= 1'b0;
            bus_ad_n_o <= 16'hFFFF;
            r_state    <= bus_sync_n ? S_IDLE : S_ADDR;
          end else bus_rply_n <= 1'b0;
        S_IAK:
          if (bus_din_n) begin
            bus_rply_n <= 1'b1;
            bus_ad_oe  <= 1'b0;
            bus_ad_n_o <= 16'hFFFF;
            r_state    <= S_IDLE;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qbus_mem_slave_ctl.sv
// tb_qbus_mem_slave_ctl: directed Q-bus transactions against a small RAM model,
// expected writes/read data queued at drive time and popped when the DUT responds.
module tb_qbus_mem_slave_ctl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_ad_n;
  logic        bus_sync_n, bus_din_n, bus_dout_n, bus_wtbt_n, bus_iako_n, irq_set;
  logic [15:0] bus_ad_n_o;
  logic        bus_ad_oe, bus_rply_n, bus_virq_n;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_be;
  logic        mem_we, mem_re;
  logic [15:0] ram [0:4095];
  logic [29:0] wq[$];
  logic [15:0] rq[$];
  int checks = 0;
  int errors = 0;

  qbus_mem_slave_ctl dut (
    .clk(clk), .rst(rst), .bus_ad_n(bus_ad_n), .bus_sync_n(bus_sync_n),
    .bus_din_n(bus_din_n), .bus_dout_n(bus_dout_n), .bus_wtbt_n(bus_wtbt_n),
    .bus_iako_n(bus_iako_n), .bus_ad_n_o(bus_ad_n_o), .bus_ad_oe(bus_ad_oe),
    .bus_rply_n(bus_rply_n), .bus_virq_n(bus_virq_n), .irq_set(irq_set),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // one-cycle-latency RAM
  always_ff @(posedge clk) begin
    if (mem_we && mem_be[0]) ram[mem_addr][7:0] <= mem_wdata[7:0];
    if (mem_we && mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus_ad_n = 16'hFFFF; bus_sync_n = 1; bus_din_n = 1; bus_dout_n = 1;
    bus_wtbt_n = 1; bus_iako_n = 1;
  endtask

  task automatic addr_ph(input logic [15:0] a);
    @(negedge clk);
    bus_ad_n = ~a; bus_wtbt_n = 1; bus_sync_n = 0;
  endtask

  task automatic end_cyc();
    @(negedge clk);
    idle_bus();
    @(negedge clk);
  endtask

  task automatic dato(input string tag, input logic [15:0] a, input logic [15:0] d,
                      input logic byte_w, input logic [1:0] be);
    @(negedge clk);
    bus_ad_n = ~d; bus_wtbt_n = ~byte_w; bus_dout_n = 0;
    wq.push_back({be, a[12:1], d});
    @(negedge clk);
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_wr"}, {mem_be, mem_addr, mem_wdata}, wq.pop_front());
    chk({tag, "_rply_early"}, bus_rply_n, 1);
    @(negedge clk);
    chk({tag, "_we_1cyc"}, mem_we, 0);
    chk({tag, "_rply"}, bus_rply_n, 0);
    bus_dout_n = 1; bus_wtbt_n = 1; bus_ad_n = 16'hFFFF;
    @(negedge clk);
    chk({tag, "_rply_rel"}, bus_rply_n, 1);
  endtask

  task automatic dati(input string tag, input logic [15:0] d);
    int n = 0;
    int re_seen = 0;
    @(negedge clk);
    bus_ad_n = 16'hFFFF; bus_din_n = 0;
    rq.push_back(~d);
    while (bus_rply_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_re === 1'b1) re_seen++;
    end
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_re"}, re_seen, 1);
    chk({tag, "_data"}, bus_ad_n_o, rq.pop_front());
    chk({tag, "_oe"}, bus_ad_oe, 1);
    bus_din_n = 1;
    @(negedge clk);
    chk({tag, "_rply_rel"}, bus_rply_n, 1);
    chk({tag, "_oe_rel"}, bus_ad_oe, 0);
    chk({tag, "_ad_rel"}, bus_ad_n_o, 16'hFFFF);
  endtask

  initial begin
    int re_seen, we_seen, lo;
    idle_bus();
    irq_set = 0;
    repeat (2) @(negedge clk);
    chk("rst_rply", bus_rply_n, 1);
    chk("rst_oe", bus_ad_oe, 0);
    chk("rst_ad", bus_ad_n_o, 16'hFFFF);
    chk("rst_virq", bus_virq_n, 1);
    chk("rst_mem", {mem_we, mem_re, mem_be, mem_addr}, 0);
    rst = 0;

    addr_ph(16'h0100); dato("dato_w", 16'h0100, 16'h1234, 0, 2'b11); end_cyc();
    addr_ph(16'h0100); dati("dati", 16'h1234); end_cyc();
    addr_ph(16'h0101); dato("datob_odd", 16'h0101, 16'hAB00, 1, 2'b10); end_cyc();
    addr_ph(16'h0101); dati("datio_r", 16'hAB34);
    dato("datio_w", 16'h0101, 16'h5678, 0, 2'b11); end_cyc();
    addr_ph(16'h0100); dati("readback", 16'h5678); end_cyc();
    addr_ph(16'h1FFE); dato("win_top", 16'h1FFE, 16'h00C3, 1, 2'b01); end_cyc();
    addr_ph(16'h1FFE); dati("win_top_r", 16'h00C3); end_cyc();

    addr_ph(16'h2000);
    @(negedge clk); bus_ad_n = 16'hFFFF; bus_din_n = 0;
    re_seen = 0; lo = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_re === 1'b1) re_seen++;
      if (bus_rply_n !== 1'b1) lo++;
    end
    chk("oow_read_re", re_seen, 0);
    chk("oow_read_rply", lo, 0);
    end_cyc();

    addr_ph(16'hE100);
    @(negedge clk); bus_ad_n = ~16'h5555; bus_dout_n = 0;
    we_seen = 0; lo = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_we === 1'b1) we_seen++;
      if (bus_rply_n !== 1'b1) lo++;
    end
    chk("oow_write_we", we_seen, 0);
    chk("oow_write_rply", lo, 0);
    end_cyc();

    @(negedge clk); bus_iako_n = 0; bus_din_n = 0;
    lo = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_rply_n !== 1'b1) lo++;
    end
    chk("iak_nopend_rply", lo, 0);
    end_cyc();

    @(negedge clk); irq_set = 1;
    @(negedge clk); irq_set = 0;
    chk("irq_virq", bus_virq_n, 0);
    bus_iako_n = 0; bus_din_n = 0;
    @(negedge clk);
    chk("iak_vec", bus_ad_n_o, 16'hFFCF);
    chk("iak_oe", bus_ad_oe, 1);
    chk("iak_rply", bus_rply_n, 0);
    chk("iak_virq_clr", bus_virq_n, 1);
    bus_iako_n = 1; bus_din_n = 1;
    @(negedge clk);
    chk("iak_rply_rel", bus_rply_n, 1);
    chk("iak_oe_rel", bus_ad_oe, 0);

    @(negedge clk); irq_set = 1;
    @(negedge clk); irq_set = 1; bus_iako_n = 0; bus_din_n = 0;
    @(negedge clk); irq_set = 0;
    chk("iak2_rply", bus_rply_n, 0);
    chk("iak2_still_pend", bus_virq_n, 0);
    bus_iako_n = 1; bus_din_n = 1;
    @(negedge clk);
    chk("iak2_rply_rel", bus_rply_n, 1);
    bus_iako_n = 0; bus_din_n = 0;
    @(negedge clk);
    chk("iak3_rply", bus_rply_n, 0);
    chk("iak3_virq_clr", bus_virq_n, 1);
    bus_iako_n = 1; bus_din_n = 1;
    @(negedge clk);

    addr_ph(16'h0100);
    @(negedge clk); bus_ad_n = 16'hFFFF; bus_din_n = 0;
    @(negedge clk);
    chk("rdw_re", mem_re, 1);
    rst = 1;
    #1;
    chk("mid_rst_re", mem_re, 0);
    chk("mid_rst_out", {bus_rply_n, bus_ad_oe, bus_ad_n_o}, {1'b1, 1'b0, 16'hFFFF});
    idle_bus();
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("post_rst_rply", bus_rply_n, 1);
    addr_ph(16'h0100); dato("post_rst_w", 16'h0100, 16'h9ABC, 0, 2'b11); end_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
